draw_sequencer: RTL and testbench

Top-level drawing controller that sits between the task start/done handshake and the VGA adapter.
- Runs fillscreen (clear pass) first, then a second drawer (e.g. circle/line) via the same level start/done handshake.
- Muxes the active source's plot stream into one registered, clipped plot port for the VGA adapter.
- Owns the start/done protocol toward the user and toward both drawers.

---
 rtl/draw_sequencer_pkg.sv | 25 ++
 rtl/draw_sequencer_if.sv | 47 ++++
 rtl/draw_sequencer_plot_clip_reg.sv | 83 ++++++++
 rtl/draw_sequencer.sv | 127 ++++++++++++
 tb/tb_draw_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/draw_sequencer_pkg.sv
// Shared types and geometry constants for the drawing sequencer slice.
package draw_pkg;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CLEAR_REL,
    DRAW,
    DRAW_REL,
    FINISH
  } seq_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_FILL,
    SRC_DRAW
  } src_sel_t;

endpackage

// File: rtl/draw_sequencer_if.sv
// Handshake and plot bus between the sequencer, the user, both drawers and the VGA adapter.
interface draw_sequencer_if;
  import draw_pkg::*;

  logic           start;
  logic           done;
  logic [C_W-1:0] clear_colour;

  logic           fill_start;
  logic [C_W-1:0] fill_colour;
  logic           fill_done;
  logic [X_W-1:0] fill_x;
  logic [Y_W-1:0] fill_y;
  logic [C_W-1:0] fill_vcolour;
  logic           fill_plot;

  logic           draw_start;
  logic           draw_done;
  logic [X_W-1:0] draw_x;
  logic [Y_W-1:0] draw_y;
  logic [C_W-1:0] draw_vcolour;
  logic           draw_plot;

  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic           vga_plot;

  // The sequencer side.
  modport master (
    input  start, clear_colour,
    input  fill_done, fill_x, fill_y, fill_vcolour, fill_plot,
    input  draw_done, draw_x, draw_y, draw_vcolour, draw_plot,
    output done, fill_start, fill_colour, draw_start,
    output vga_x, vga_y, vga_colour, vga_plot
  );

  // User, drawers and VGA adapter seen as one environment.
  modport slave (
    output start, clear_colour,
    output fill_done, fill_x, fill_y, fill_vcolour, fill_plot,
    output draw_done, draw_x, draw_y, draw_vcolour, draw_plot,
    input  done, fill_start, fill_colour, draw_start,
    input  vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/draw_sequencer_plot_clip_reg.sv
// One-cycle registered plot mux: picks the active source, suppresses off-screen pixels.
module plot_clip_reg
  import draw_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  src_sel_t       sel,
  input  logic [X_W-1:0] fill_x,
  input  logic [Y_W-1:0] fill_y,
  input  logic [C_W-1:0] fill_colour,
  input  logic           fill_plot,
  input  logic [X_W-1:0] draw_x,
  input  logic [Y_W-1:0] draw_y,
  input  logic [C_W-1:0] draw_colour,
  input  logic           draw_plot,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  logic [X_W-1:0] x_p0;
  logic [Y_W-1:0] y_p0;
  logic [C_W-1:0] colour_p0;
  logic           plot_p0;
  logic           vld_p0;

  logic [X_W-1:0] x_p1;
  logic [Y_W-1:0] y_p1;
  logic [C_W-1:0] colour_p1;
  logic           vld_p1;

  // Stage p0: source select and on-screen test.
  always_comb begin
    x_p0      = '0;
    y_p0      = '0;
    colour_p0 = '0;
    plot_p0   = 1'b0;
    case (sel)
      SRC_FILL: begin
        x_p0      = fill_x;
        y_p0      = fill_y;
        colour_p0 = fill_colour;
        plot_p0   = fill_plot;
      end
      SRC_DRAW: begin
        x_p0      = draw_x;
        y_p0      = draw_y;
        colour_p0 = draw_colour;
        plot_p0   = draw_plot;
      end
      default: ;
    endcase
  end

  assign vld_p0 = plot_p0 && (32'(x_p0) < SCREEN_W) && (32'(y_p0) < SCREEN_H);

  // Stage p1: coordinates only move on an accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p1      <= '0;
      y_p1      <= '0;
      colour_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        x_p1      <= x_p0;
        y_p1      <= y_p0;
        colour_p1 <= colour_p0;
      end
    end
  end

  assign vga_x      = x_p1;
  assign vga_y      = y_p1;
  assign vga_colour = colour_p1;
  assign vga_plot   = vld_p1;

endmodule

// File: rtl/draw_sequencer.sv
// Clear-then-draw sequencer with a registered, clipped plot port.
// Optional accepted-pixel counter enabled by DRAW_SEQUENCER_PIXCOUNT_EN.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  draw_sequencer_if.master   bus
`ifdef DRAW_SEQUENCER_PIXCOUNT_EN
  ,
  output logic [15:0]        pix_count
`endif
);

  seq_state_t state;
  src_sel_t   sel;

  assign bus.fill_colour = bus.clear_colour;

  // done only rises once start is seen high in FINISH; the return to IDLE
  // waits for that acknowledgement so an early start drop is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.done       <= 1'b0;
      bus.fill_start <= 1'b0;
      bus.draw_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= CLEAR;
            bus.fill_start <= 1'b1;
          end
        end
        CLEAR: begin
          if (bus.fill_done) begin
            state          <= CLEAR_REL;
            bus.fill_start <= 1'b0;
          end
        end
        CLEAR_REL: begin
          if (!bus.fill_done) begin
            state          <= DRAW;
            bus.draw_start <= 1'b1;
          end
        end
        DRAW: begin
          if (bus.draw_done) begin
            state          <= DRAW_REL;
            bus.draw_start <= 1'b0;
          end
        end
        DRAW_REL: begin
          if (!bus.draw_done) begin
            state    <= FINISH;
            bus.done <= bus.start;
          end
        end
        FINISH: begin
          if (bus.done && !bus.start) begin
            state    <= IDLE;
            bus.done <= 1'b0;
          end else begin
            bus.done <= bus.start;
          end
        end
        default: begin
          state          <= IDLE;
          bus.done       <= 1'b0;
          bus.fill_start <= 1'b0;
          bus.draw_start <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sel = SRC_NONE;
    case (state)
      CLEAR, CLEAR_REL: sel = SRC_FILL;
      DRAW, DRAW_REL:   sel = SRC_DRAW;
      default:          sel = SRC_NONE;
    endcase
  end

  plot_clip_reg #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_plot (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .fill_x      (bus.fill_x),
    .fill_y      (bus.fill_y),
    .fill_colour (bus.fill_vcolour),
    .fill_plot   (bus.fill_plot),
    .draw_x      (bus.draw_x),
    .draw_y      (bus.draw_y),
    .draw_colour (bus.draw_vcolour),
    .draw_plot   (bus.draw_plot),
    .vga_x       (bus.vga_x),
    .vga_y       (bus.vga_y),
    .vga_colour  (bus.vga_colour),
    .vga_plot    (bus.vga_plot)
  );

`ifdef DRAW_SEQUENCER_PIXCOUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count <= '0;
    end else if (state == IDLE && bus.start) begin
      pix_count <= '0;
    end else if (bus.vga_plot) begin
      pix_count <= sat_inc(pix_count);
    end
  end
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed sequence with randomized pixels, checked against a screen-rule reference stream.
module tb_draw_sequencer;

  localparam int SW = 160;
  localparam int SH = 120;

  logic clk = 1'b0;
  logic rst_n;
  draw_sequencer_if bus ();
`ifdef DRAW_SEQUENCER_PIXCOUNT_EN
  logic [15:0] pix_count;
`endif

  draw_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DRAW_SEQUENCER_PIXCOUNT_EN
    ,
    .pix_count (pix_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] obs_q[$];
  logic [17:0] exp_q[$];
  logic both_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.vga_plot === 1'b1) obs_q.push_back({bus.vga_x, bus.vga_y, bus.vga_colour});
      if (bus.fill_start === 1'b1 && bus.draw_start === 1'b1) both_seen <= 1'b1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a pixel reaches the screen iff it lies inside the visible area.
  task automatic push_exp(input int x, input int y, input int c);
    if (x < SW && y < SH) exp_q.push_back({8'(x), 7'(y), 3'(c)});
  endtask

  task automatic compare_stream(input string tag);
    int first_bad = -1;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] && first_bad < 0) first_bad = i;
    check({tag, "_first_bad_idx"}, first_bad, -1);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_fill_start(input logic v, input string tag);
    int b = 0;
    while (bus.fill_start !== v && b < 8) begin tick(); b++; end
    check(tag, int'(bus.fill_start), int'(v));
  endtask

  task automatic wait_draw_start(input logic v, input string tag);
    int b = 0;
    while (bus.draw_start !== v && b < 8) begin tick(); b++; end
    check(tag, int'(bus.draw_start), int'(v));
  endtask

  // Behavioural fillscreen: column-major sweep in the forwarded colour.
  task automatic run_fill(input int cols, input int cc);
    for (int x = 0; x < cols; x++) begin
      for (int y = 0; y < SH; y++) begin
        bus.fill_x       = 8'(x);
        bus.fill_y       = 7'(y);
        bus.fill_vcolour = bus.fill_colour;
        bus.fill_plot    = 1'b1;
        push_exp(x, y, cc);
        tick();
      end
    end
    bus.fill_plot = 1'b0;
    bus.fill_done = 1'b1;
    tick();
    wait_fill_start(1'b0, "fill_start_release");
    bus.fill_done = 1'b0;
  endtask

  task automatic dplot(input int x, input int y, input int c, input logic p, input logic d);
    bus.draw_x       = 8'(x);
    bus.draw_y       = 7'(y);
    bus.draw_vcolour = 3'(c);
    bus.draw_plot    = p;
    bus.draw_done    = d;
    if (p) push_exp(x, y, c);
    tick();
  endtask

  initial begin
    int cc, dc, exp_pix, b;
    int cx[4] = '{159, 160, 5, 255};
    int cy[4] = '{119, 5, 120, 127};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.clear_colour = '0;
    bus.fill_done = 1'b0; bus.fill_x = '0; bus.fill_y = '0; bus.fill_vcolour = '0; bus.fill_plot = 1'b0;
    bus.draw_done = 1'b0; bus.draw_x = '0; bus.draw_y = '0; bus.draw_vcolour = '0; bus.draw_plot = 1'b0;
    tick(); tick();
    check("rst_done", int'(bus.done), 0);
    check("rst_fill_start", int'(bus.fill_start), 0);
    check("rst_draw_start", int'(bus.draw_start), 0);
    check("rst_vga", int'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_no_start", int'(bus.fill_start), 0);

    // Full run: complete clear pass then two drawer pixels, last one with done.
    cc = int'($urandom_range(0, 7));
    dc = int'($urandom_range(0, 7));
    bus.clear_colour = 3'(cc);
    bus.start = 1'b1;
    wait_fill_start(1'b1, "a_fill_start");
    check("a_fill_colour", int'(bus.fill_colour), cc);
    run_fill(SW, cc);
    wait_draw_start(1'b1, "a_draw_start");
    dplot(10, 10, dc, 1'b1, 1'b0);
    dplot(11, 10, dc, 1'b1, 1'b1);
    bus.draw_plot = 1'b0;
    wait_draw_start(1'b0, "a_draw_release");
    bus.draw_done = 1'b0;
    b = 0;
    while (bus.done !== 1'b1 && b < 8) begin tick(); b++; end
    check("a_done", int'(bus.done), 1);
    check("a_total_plots", obs_q.size(), SW * SH + 2);
`ifdef DRAW_SEQUENCER_PIXCOUNT_EN
    check("a_pix_count", int'(pix_count), SW * SH + 2);
`endif
    compare_stream("a_stream");
    bus.start = 1'b0;
    tick();
    check("a_done_drop", int'(bus.done), 0);
    tick(); tick();
    check("a_back_idle", int'(bus.fill_start), 0);

    // Early start drop, latency/hold, clipping, random drawer pixels.
    cc = int'($urandom_range(0, 7));
    bus.clear_colour = 3'(cc);
    bus.start = 1'b1;
    wait_fill_start(1'b1, "b_fill_start");
    bus.start = 1'b0;
    run_fill(2, cc);
    wait_draw_start(1'b1, "b_draw_start");
    dplot(42, 17, 5, 1'b1, 1'b0);
    check("lat_x", int'(bus.vga_x), 42);
    check("lat_y", int'(bus.vga_y), 17);
    check("lat_colour", int'(bus.vga_colour), 5);
    check("lat_plot", int'(bus.vga_plot), 1);
    dplot(99, 88, 2, 1'b0, 1'b0);
    check("hold_plot", int'(bus.vga_plot), 0);
    check("hold_xy", int'({bus.vga_x, bus.vga_y}), int'({8'd42, 7'd17}));
    for (int i = 0; i < 4; i++) begin
      dplot(cx[i], cy[i], 3, 1'b1, 1'b0);
      check($sformatf("clip_%0d_plot", i), int'(bus.vga_plot), int'(cx[i] < SW && cy[i] < SH));
    end
    dplot(0, 0, 0, 1'b0, 1'b0);
    check("clip_hold_xy", int'({bus.vga_x, bus.vga_y}), int'({8'd159, 7'd119}));
    for (int i = 0; i < 40; i++)
      dplot(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'b0);
    dplot(0, 0, 0, 1'b0, 1'b1);
    wait_draw_start(1'b0, "b_draw_release");
    bus.draw_done = 1'b0;
    tick(); tick(); tick();
    check("b_done_waits", int'(bus.done), 0);
    check("b_no_restart", int'(bus.fill_start), 0);
    exp_pix = exp_q.size();
    bus.start = 1'b1;
    tick();
    check("b_done_on_start", int'(bus.done), 1);
    bus.start = 1'b0;
    tick();
    check("b_done_drop", int'(bus.done), 0);
`ifdef DRAW_SEQUENCER_PIXCOUNT_EN
    tick();
    check("b_pix_count_hold", int'(pix_count), exp_pix);
`endif
    compare_stream("b_stream");

    // Asynchronous reset in the middle of the drawer pass.
    bus.start = 1'b1;
    wait_fill_start(1'b1, "c_fill_start");
    run_fill(1, int'(bus.clear_colour));
    wait_draw_start(1'b1, "c_draw_start");
    dplot(3, 4, 2, 1'b1, 1'b0);
    bus.draw_x = 8'd7;
    rst_n = 1'b0;
    #1;
    check("c_rst_done", int'(bus.done), 0);
    check("c_rst_starts", int'({bus.fill_start, bus.draw_start}), 0);
    check("c_rst_vga", int'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}), 0);
`ifdef DRAW_SEQUENCER_PIXCOUNT_EN
    check("c_rst_pix_count", int'(pix_count), 0);
`endif
    bus.start = 1'b0;
    bus.draw_plot = 1'b0;
    tick();
    obs_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("c_no_plots", obs_q.size(), 0);
    check("c_idle", int'(bus.fill_start), 0);

    check("no_dual_start", int'(both_seen), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
